// File: rtl/wb_commit.sv
// wb_commit: commits one write-back packet every two cycles into a 32x32 register
// file and the PC, forwarding the pending packet to two decode read ports.
module wb_commit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic        reg_update,
  input  logic [31:0] reg_new,
  input  logic [4:0]  rd,
  input  logic        pc_update,
  input  logic [31:0] pc_new,
  input  logic [4:0]  rs_a,
  input  logic [4:0]  rs_b,
  output logic [31:0] rdata_a,
  output logic [31:0] rdata_b,
  output logic [31:0] pc,
  output logic        commit_done,
  output logic [31:0] retired
);

  typedef enum logic {IDLE, WRITE} state_e;

  state_e      state_q, state_d;
  logic        pend_reg_update_q, pend_reg_update_d;
  logic [4:0]  pend_rd_q, pend_rd_d;
  logic [31:0] pend_reg_new_q, pend_reg_new_d;
  logic        pend_pc_update_q, pend_pc_update_d;
  logic [31:0] pend_pc_new_q, pend_pc_new_d;
  logic [31:0] regfile_q [32];
  logic [31:0] regfile_d [32];
  logic [31:0] pc_q, pc_d;
  logic [31:0] retired_q, retired_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= IDLE;
      pend_reg_update_q <= 1'b0;
      pend_rd_q         <= 5'd0;
      pend_reg_new_q    <= 32'd0;
      pend_pc_update_q  <= 1'b0;
      pend_pc_new_q     <= 32'd0;
      pc_q              <= RESET_PC;
      retired_q         <= 32'd0;
      for (int i = 0; i < 32; i++) regfile_q[i] <= 32'd0;
    end else begin
      state_q           <= state_d;
      pend_reg_update_q <= pend_reg_update_d;
      pend_rd_q         <= pend_rd_d;
      pend_reg_new_q    <= pend_reg_new_d;
      pend_pc_update_q  <= pend_pc_update_d;
      pend_pc_new_q     <= pend_pc_new_d;
      pc_q              <= pc_d;
      retired_q         <= retired_d;
      for (int i = 0; i < 32; i++) regfile_q[i] <= regfile_d[i];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (wb_valid) state_d = WRITE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture in IDLE, commit in WRITE; the two never overlap.
  always_comb begin
    pend_reg_update_d = pend_reg_update_q;
    pend_rd_d         = pend_rd_q;
    pend_reg_new_d    = pend_reg_new_q;
    pend_pc_update_d  = pend_pc_update_q;
    pend_pc_new_d     = pend_pc_new_q;
    pc_d              = pc_q;
    retired_d         = retired_q;
    for (int i = 0; i < 32; i++) regfile_d[i] = regfile_q[i];
    if (state_q == IDLE && wb_valid) begin
      pend_reg_update_d = reg_update;
      pend_rd_d         = rd;
      pend_reg_new_d    = reg_new;
      pend_pc_update_d  = pc_update;
      pend_pc_new_d     = pc_new;
    end
    if (state_q == WRITE) begin
      if (pend_reg_update_q && pend_rd_q != 5'd0) regfile_d[pend_rd_q] = pend_reg_new_q;
      pc_d      = pend_pc_update_q ? pend_pc_new_q : pc_q + PC_STEP;
      retired_d = retired_q + 32'd1;
    end
  end

  always_comb begin
    wb_ready    = (state_q == IDLE);
    commit_done = (state_q == WRITE);
    pc          = pc_q;
    retired     = retired_q;
    if (rs_a == 5'd0) rdata_a = 32'd0;
    else if (state_q == WRITE && pend_reg_update_q && pend_rd_q == rs_a) rdata_a = pend_reg_new_q;
    else rdata_a = regfile_q[rs_a];
    if (rs_b == 5'd0) rdata_b = 32'd0;
    else if (state_q == WRITE && pend_reg_update_q && pend_rd_q == rs_b) rdata_b = pend_reg_new_q;
    else rdata_b = regfile_q[rs_b];
  end

endmodule

// File: tb/tb_wb_commit.sv
// tb_wb_commit: directed and random packets against a packet-level model of the
// commit unit (accept a packet, commit it one edge later).
`timescale 1ns/1ps
module tb_wb_commit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_valid, wb_ready, reg_update, pc_update, commit_done;
  logic [31:0] reg_new, pc_new, rdata_a, rdata_b, pc, retired;
  logic [4:0]  rd, rs_a, rs_b;

  int errors = 0;
  int checks = 0;
  bit last_accept;

  bit          m_busy;
  bit          m_ru, m_pu;
  logic [4:0]  m_rd;
  logic [31:0] m_val, m_pnew, m_pc, m_retired;
  logic [31:0] m_regs [32];

  wb_commit #(.RESET_PC(32'h0000_0000), .PC_STEP(32'd4)) dut (
    .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .reg_update(reg_update), .reg_new(reg_new), .rd(rd),
    .pc_update(pc_update), .pc_new(pc_new), .rs_a(rs_a), .rs_b(rs_b),
    .rdata_a(rdata_a), .rdata_b(rdata_b), .pc(pc),
    .commit_done(commit_done), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] modelRead(input logic [4:0] rs);
    if (rs == 5'd0) return 32'd0;
    if (m_busy && m_ru && m_rd == rs) return m_val;
    return m_regs[rs];
  endfunction

  task automatic modelReset();
    m_busy = 0; m_ru = 0; m_pu = 0; m_rd = '0; m_val = '0; m_pnew = '0;
    m_pc = 32'h0000_0000; m_retired = 32'd0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, ".wb_ready"}, {31'd0, wb_ready}, {31'd0, !m_busy});
    checkOutput({tag, ".commit_done"}, {31'd0, commit_done}, {31'd0, m_busy});
    checkOutput({tag, ".pc"}, pc, m_pc);
    checkOutput({tag, ".retired"}, retired, m_retired);
    checkOutput({tag, ".rdata_a"}, rdata_a, modelRead(rs_a));
    checkOutput({tag, ".rdata_b"}, rdata_b, modelRead(rs_b));
  endtask

  // Model of one rising edge: a pending packet commits, otherwise a valid one is taken.
  task automatic modelEdge();
    if (m_busy) begin
      if (m_ru && m_rd != 5'd0) m_regs[m_rd] = m_val;
      m_pc = m_pu ? m_pnew : m_pc + 32'd4;
      m_retired = m_retired + 32'd1;
      m_busy = 0;
    end else if (wb_valid) begin
      m_ru = reg_update; m_rd = rd; m_val = reg_new; m_pu = pc_update; m_pnew = pc_new;
      m_busy = 1;
    end
  endtask

  // Called at posedge+1; returns at the next posedge+1.
  task automatic applyStimulus(input string tag, input bit v, input bit ru, input logic [4:0] d,
                               input logic [31:0] val, input bit pu, input logic [31:0] pn,
                               input logic [4:0] ra, input logic [4:0] rb);
    wb_valid = v; reg_update = ru; rd = d; reg_new = val; pc_update = pu; pc_new = pn;
    rs_a = ra; rs_b = rb;
    #2;
    checkModel(tag);
    last_accept = wb_valid && wb_ready;
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic sendPacket(input string tag, input bit ru, input logic [4:0] d,
                            input logic [31:0] val, input bit pu, input logic [31:0] pn);
    applyStimulus({tag, ".hs"}, 1'b1, ru, d, val, pu, pn, d, d);
    applyStimulus({tag, ".wr"}, 1'b0, ru, d, val, pu, pn, d, d);
  endtask

  initial begin
    int acc;
    logic [31:0] r0, p0;
    rst_n = 1'b0; wb_valid = 0; reg_update = 0; pc_update = 0;
    rd = '0; reg_new = '0; pc_new = '0; rs_a = '0; rs_b = '0;
    modelReset();
    @(posedge clk); #3;
    checkModel("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    sendPacket("regwr", 1'b1, 5'd3, 32'hDEAD_BEEF, 1'b0, 32'd0);
    checkOutput("regwr_pc", pc, 32'd4);
    checkOutput("regwr_retired", retired, 32'd1);
    applyStimulus("regwr_read", 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 5'd3, 5'd3);

    sendPacket("branch", 1'b0, 5'd3, 32'h1111_1111, 1'b1, 32'h0000_0100);
    checkOutput("branch_pc", pc, 32'h0000_0100);
    for (int i = 0; i < 16; i++)
      applyStimulus("branch_sweep", 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 5'(i), 5'(i + 16));

    p0 = m_pc;
    sendPacket("reg0", 1'b1, 5'd0, 32'h0000_1234, 1'b0, 32'd0);
    checkOutput("reg0_pc", pc, p0 + 32'd4);
    applyStimulus("reg0_read", 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 5'd0, 5'd0);
    sendPacket("reg5", 1'b1, 5'd5, 32'hCAFE_0005, 1'b0, 32'd0);

    acc = 0;
    r0 = m_retired;
    for (int i = 0; i < 6; i++) begin
      applyStimulus("bp", 1'b1, 1'b1, 5'($urandom_range(1, 31)), $urandom, 1'b0, 32'd0,
                    5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      acc += int'(last_accept);
    end
    checkOutput("bp_accepts", acc, 32'd3);
    checkOutput("bp_retired", retired, r0 + 32'd3);

    sendPacket("pcwrap_br", 1'b0, 5'd0, 32'd0, 1'b1, 32'hFFFF_FFFC);
    sendPacket("pcwrap", 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
    checkOutput("pc_wrap", pc, 32'h0000_0000);

    force dut.retired_d = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    release dut.retired_d;
    m_retired = 32'hFFFF_FFFF;
    checkOutput("retired_preset", retired, 32'hFFFF_FFFF);
    sendPacket("retwrap", 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
    checkOutput("retired_wrap", retired, 32'd0);

    for (int i = 0; i < 300; i++) begin
      logic [4:0] rdr, ra, rb;
      rdr = 5'($urandom_range(0, 31));
      ra = ($urandom_range(0, 1) == 1) ? m_rd : 5'($urandom_range(0, 31));
      rb = ($urandom_range(0, 1) == 1) ? m_rd : 5'($urandom_range(0, 31));
      applyStimulus("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), rdr,
                    $urandom, ($urandom_range(0, 3) == 0), $urandom, ra, rb);
    end
    while (m_busy) applyStimulus("drain", 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 5'd5, 5'd5);

    applyStimulus("rstw_hs", 1'b1, 1'b1, 5'd5, 32'h5555_5555, 1'b0, 32'd0, 5'd5, 5'd5);
    wb_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkModel("rstw_async");
    @(posedge clk); #1;
    checkModel("rstw_hold");
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkModel("rstw_after");
    applyStimulus("rstw_idle", 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 5'd5, 5'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
